fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Fetch controller that owns the program counter and sequences instruction-memory reads for the pipelined MIPS core. It replaces the free-running PC-plus-4 fetch with a request/ready memory handshake. It applies next-PC priority: exception vector, ERET, branch/jump redirect, sequential. It presents one fetched instruction per handshake to decode, honouring decode stalls.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
EXC_VECTOR, 32'h0000_4180, exception entry address
IMEM_BASE, 32'h0000_3000, lowest legal fetch address; imem_addr is a byte address relative to this base

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
imem_req  out  1  read request to instruction memory
imem_addr  out  32  byte offset (pc - IMEM_BASE), word aligned
imem_ready  in  1  memory returns imem_rdata this cycle; transfer = imem_req & imem_ready
imem_rdata  in  32  instruction word
stall  in  1  decode cannot accept if_* this cycle
redirect_valid  in  1  branch/jump taken, flush fetch
redirect_pc  in  32  redirect target
exc_req  in  1  take exception
eret_req  in  1  return from exception
epc  in  32  ERET target
if_valid  out  1  if_instr/if_pc valid to decode
if_instr  out  32  fetched instruction
if_pc  out  32  PC of if_instr
fetch_pc  out  32  PC of current/next request

Behaviour:
- Reset (reset=0, async, no clock needed): pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=RESET_PC, park reg=0.
- Decode consumes when if_valid & !stall. "Slot free" = !if_valid | !stall.
- States: IDLE, FETCH, PARK, DROP; 2-bit encoding.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=pc-IMEM_BASE. Once asserted, addr is held stable until transfer.
  - Transfer with slot free: if_instr=imem_rdata, if_pc=pc, if_valid=1, pc+=4, stay FETCH. The next request issues the following cycle. Back-to-back zero-wait reads give one instruction per cycle.
  - Transfer with slot full (stall high): data into park reg (instr, pc), pc+=4 -> PARK.
  - No transfer: if_valid clears on consume.
- PARK: imem_req=0. When slot free: if_* = park, if_valid=1 -> FETCH.
- DROP: imem_req held, same addr. On imem_ready, discard data -> FETCH with the already-loaded new pc. No if_valid.
- Flush event priority: exc_req > eret_req > redirect_valid. Target is EXC_VECTOR / epc / redirect_pc respectively.
  - On any flush: pc=target; if_valid=0 next cycle; park discarded.
  - If a request is outstanding (FETCH, req high, no ready this cycle): -> DROP.
  - Otherwise (including a transfer in the same cycle, whose data is discarded): -> FETCH.
- Flush during DROP: update pc, stay DROP.
- Flush in same cycle as consume: flush wins; consumed instr is not re-presented.
- pc arithmetic is 32-bit wrap; pc[1:0] forced 00 when loaded (without option).
- fetch_pc = pc at all times.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: extra output if_adel (1 bit, reset 0).
  - A target with pc[1:0]!=0, or pc < IMEM_BASE, issues no memory request.
  - Next slot-free cycle: if_valid=1, if_instr=0 (NOP), if_pc=pc, if_adel=1. FSM then waits in FETCH with req low until a flush.
- Undefined: no if_adel port; low bits truncated; no range check.

Test Plan:
1. Release reset, imem_ready=1, stall=0 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc 0x3000,0x3004,0x3008 one cycle later; if_valid continuous.
2. Memory 3-cycle latency -> imem_req high and imem_addr 0x0 stable 3 cycles; single if_valid pulse with rdata; if_pc=0x3000.
3. redirect_valid, redirect_pc=0x3100 while read of 0x3008 outstanding -> DROP; returned word never on if_instr; next request addr 0x100; if_pc 0x3100.
4. exc_req, redirect_valid and eret_req same cycle -> next fetch_pc 0x4180. Later eret_req, epc=0x3040 -> fetch_pc 0x3040, if_valid low one cycle.
5. stall high from cycle before transfer of 0x300C for 4 cycles -> if_instr/if_pc frozen at 0x3008, imem_req low in PARK. After release, 0x300C presented once, then 0x3010; no loss, no duplicate.
6. reset driven low mid-DROP with no clock edge -> imem_req=0, if_valid=0, fetch_pc=0x3000 immediately. After release, first request addr 0x0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC and sequences instruction-memory reads for decode.
// Latency: one cycle from an imem transfer to if_valid; zero-wait memory gives one instruction per cycle.
// Backpressure: a word fetched while decode stalls is held in a park register and imem_req drops until decode frees the slot.
//
// Ports: clk/reset (async active-low); imem_req/imem_addr/imem_ready/imem_rdata memory handshake;
// stall from decode; redirect_valid/redirect_pc, exc_req, eret_req/epc flush sources;
// if_valid/if_instr/if_pc to decode; fetch_pc mirrors the PC register.
// Optional: define FETCH_ALIGN_CHECK_EN for address-error detection and the if_adel output.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PARK = 2'd2, DROP = 2'd3} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] park_instr;
  logic [31:0] park_pc;
  logic [31:0] drop_addr;   // address of the request being drained after a flush
  logic [31:0] flush_tgt;
  logic [31:0] ld_pc;
  logic [31:0] pc_inc;
  logic        slot_free;
  logic        xfer;
  logic        flush;
  logic        cur_bad;
  logic        ld_bad;
  logic        inc_bad;

  assign slot_free = !if_valid || !stall;
  assign xfer      = imem_req && imem_ready;
  assign flush     = exc_req || eret_req || redirect_valid;
  assign flush_tgt = exc_req ? EXC_VECTOR : (eret_req ? epc : redirect_pc);
  assign pc_inc    = pc + 32'd4;
  assign fetch_pc  = pc;
  // While draining, the old request's address must stay on the bus even though pc already holds the new target.
  assign imem_addr = (state == DROP) ? drop_addr : (pc - IMEM_BASE);

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_done;   // the address-error NOP for the current pc has already been issued
  assign ld_pc   = flush_tgt;
  assign cur_bad = (pc[1:0] != 2'b00) || (pc < IMEM_BASE);
  assign ld_bad  = (ld_pc[1:0] != 2'b00) || (ld_pc < IMEM_BASE);
  assign inc_bad = (pc_inc[1:0] != 2'b00) || (pc_inc < IMEM_BASE);
`else
  assign ld_pc   = flush_tgt & 32'hFFFF_FFFC;
  assign cur_bad = 1'b0;
  assign ld_bad  = 1'b0;
  assign inc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= RESET_PC;
      park_instr <= 32'd0;
      park_pc    <= 32'd0;
      drop_addr  <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      if_adel    <= 1'b0;
      adel_done  <= 1'b0;
`endif
    end else begin
      // Decode takes the presented word; later branches may present a new one.
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if_adel  <= 1'b0;
`endif
      end

      if (flush) begin
        // Flush beats a same-cycle consume; any parked word is simply abandoned.
        pc       <= ld_pc;
        if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if_adel   <= 1'b0;
        adel_done <= 1'b0;
`endif
        if (state == DROP) begin
          imem_req <= 1'b1;
        end else if (state == FETCH && imem_req && !imem_ready) begin
          state     <= DROP;
          drop_addr <= pc - IMEM_BASE;
          imem_req  <= 1'b1;
        end else begin
          state    <= FETCH;
          imem_req <= !ld_bad;
        end
      end else begin
        case (state)
          IDLE: begin
            state    <= FETCH;
            imem_req <= !cur_bad;
          end
          FETCH: begin
            if (xfer) begin
              pc <= pc_inc;
              if (slot_free) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                imem_req <= !inc_bad;
              end else begin
                park_instr <= imem_rdata;
                park_pc    <= pc;
                state      <= PARK;
                imem_req   <= 1'b0;
              end
`ifdef FETCH_ALIGN_CHECK_EN
            end else if (cur_bad && !adel_done && slot_free) begin
              // Illegal pc: hand decode a NOP flagged as an address error, then idle until a flush.
              if_valid  <= 1'b1;
              if_instr  <= 32'd0;
              if_pc     <= pc;
              if_adel   <= 1'b1;
              adel_done <= 1'b1;
`endif
            end
          end
          PARK: begin
            if (slot_free) begin
              if_instr <= park_instr;
              if_pc    <= park_pc;
              if_valid <= 1'b1;
              state    <= FETCH;
              imem_req <= !cur_bad;
            end
          end
          DROP: begin
            if (imem_ready) begin
              state    <= FETCH;
              imem_req <= !cur_bad;
            end
          end
          default: begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
